// File: rtl/sseg_mux4.sv
// sseg_mux4: frame-atomic 4-digit seven-segment multiplexer with inter-digit blanking and frame-start pulse
module sseg_mux4 #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_start
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][7:0]  sh_q, sh_d;
  logic [3:0]       an_d;
  logic [7:0]       sseg_d;
  logic             wrap, cap, lit;
  always_comb begin
    wrap   = cnt_q == CNT_W'(DIGIT_CYCLES - 1);
    cap    = enable && cnt_q == '0 && idx_q == 2'd0;
    cnt_d  = !enable ? cnt_q : wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d  = enable && wrap ? idx_q + 2'd1 : idx_q;
    sh_d   = cap ? {in3, in2, in1, in0} : sh_q;
    // outputs are driven from next-state so they line up with cnt/idx after the edge
    lit    = enable && cnt_d >= CNT_W'(BLANK_CYCLES);
    an_d   = lit ? ~(4'b0001 << idx_d) : 4'hF;
    sseg_d = lit ? sh_d[idx_d] : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= {4{8'hFF}};
      an          <= 4'hF;
      sseg        <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      an          <= an_d;
      sseg        <= sseg_d;
      frame_start <= cap;
    end
  end
endmodule

// File: tb/tb_sseg_mux4.sv
// tb_sseg_mux4: randomized self-checking bench for sseg_mux4 against a frame-position model
module tb_sseg_mux4;
  logic       clk = 0, reset = 1, enable = 1;
  logic [7:0] in0 = 8'hC0, in1 = 8'hF9, in2 = 8'hA4, in3 = 8'hB0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_start;
  int         n_cmp = 0, n_bad = 0;
  int         t = 0;
  logic [7:0] msh [4] = '{default: 8'hFF};
  logic [3:0] e_an = 4'hF;
  logic [7:0] e_sseg = 8'hFF;
  logic       e_fs = 0;

  sseg_mux4 #(.DIGIT_CYCLES(8), .BLANK_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .an(an), .sseg(sseg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // model: t is the position within a 32-cycle frame; slot = t/8, offset = t%8
  task automatic tick();
    logic [7:0] inv [4];
    inv = '{in0, in1, in2, in3};
    if (reset) begin
      t = 0; msh = '{default: 8'hFF}; e_an = 4'hF; e_sseg = 8'hFF; e_fs = 0;
    end else if (!enable) begin
      e_an = 4'hF; e_sseg = 8'hFF; e_fs = 0;
    end else begin
      e_fs = (t == 0);
      if (t == 0) msh = inv;
      t = (t + 1) % 32;
      e_an   = (t % 8 < 2) ? 4'hF : ~(4'b0001 << (t / 8));
      e_sseg = (t % 8 < 2) ? 8'hFF : msh[t / 8];
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got an=%b sseg=%h fs=%b, want 1111/ff/0", i, an, sseg, frame_start);
      end
    end
  endtask

  task automatic test_frames();
    logic [3:0] prev_an = 4'hF;
    int blank_run = 2;
    reset = 0;
    for (int i = 0; i < 96; i++) begin
      tick();
      n_cmp++;
      if (an !== e_an || sseg !== e_sseg || frame_start !== e_fs) begin
        n_bad++;
        $display("FAIL frames i=%0d: got %b/%h/%b want %b/%h/%b", i, an, sseg, frame_start, e_an, e_sseg, e_fs);
      end
      n_cmp++;
      if ($countones(~an) > 1 || (an === 4'hF && sseg !== 8'hFF) ||
          (an !== 4'hF && an !== prev_an && blank_run < 2)) begin
        n_bad++;
        $display("FAIL invariant i=%0d: an=%b sseg=%h blank_run=%0d", i, an, sseg, blank_run);
      end
      blank_run = (an === 4'hF) ? blank_run + 1 : 0;
      prev_an = an;
    end
  endtask

  task automatic test_capture_atomic();
    logic [3:0] targets [4] = '{4'b1101, 4'b1011, 4'b0001, 4'b1011};
    logic [7:0] want [4] = '{8'h00, 8'hA4, 8'h00, 8'h99};
    for (int s = 0; s < 4; s++) begin
      bit found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
        tick();
        n_cmp++;
        if (an !== e_an || sseg !== e_sseg || frame_start !== e_fs) begin
          n_bad++;
          $display("FAIL capture i=%0d: got %b/%h/%b want %b/%h/%b", i, an, sseg, frame_start, e_an, e_sseg, e_fs);
        end
        found = (s == 2) ? frame_start === 1'b1 : an === targets[s];
      end
      n_cmp++;
      if (!found) begin
        n_bad++;
        $display("FAIL capture_wait stage %0d: timed out, got an=%b want %b", s, an, targets[s]);
      end else if (s == 1 || s == 3) begin
        n_cmp++;
        if (sseg !== want[s]) begin
          n_bad++;
          $display("FAIL capture_digit2 stage %0d: got %h want %h", s, sseg, want[s]);
        end
      end
      if (s == 0) in2 = 8'h99;
    end
  endtask

  task automatic test_enable_freeze();
    bit found = 0;
    int gap = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      found = (t == 13);
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL freeze_wait: never reached idx=1 cnt=5, t=%0d", t);
    end
    enable = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); gap++;
      n_cmp++;
      if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b0) begin
        n_bad++;
        $display("FAIL freeze[%0d]: got %b/%h/%b want 1111/ff/0", i, an, sseg, frame_start);
      end
    end
    enable = 1;
    tick(); gap++;
    n_cmp++;
    if (an !== 4'b1101 || sseg !== 8'hF9) begin
      n_bad++;
      $display("FAIL resume: got %b/%h want 1101/f9", an, sseg);
    end
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick(); gap++;
      n_cmp++;
      if (an !== e_an || sseg !== e_sseg || frame_start !== e_fs) begin
        n_bad++;
        $display("FAIL freeze_run i=%0d: got %b/%h/%b want %b/%h/%b", i, an, sseg, frame_start, e_an, e_sseg, e_fs);
      end
      found = frame_start === 1'b1;
    end
    n_cmp++;
    if (!found || gap != 30) begin
      n_bad++;
      $display("FAIL freeze_gap: got %0d cycles (found=%0d) want 30", gap, found);
    end
  endtask

  task automatic test_reset_midframe();
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      found = an === 4'b0111;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL midreset_wait: digit 3 never lit, an=%b", an);
    end
    reset = 1; in0 = 8'h88;
    tick();
    n_cmp++;
    if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: got %b/%h/%b want 1111/ff/0", an, sseg, frame_start);
    end
    reset = 0;
    tick();
    n_cmp++;
    if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_capture: got %b/%h/%b want 1111/ff/1", an, sseg, frame_start);
    end
    tick();
    n_cmp++;
    if (an !== 4'b1110 || sseg !== 8'h88 || frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_restart: got %b/%h/%b want 1110/88/0", an, sseg, frame_start);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom % 8) != 0;
      reset  = ($urandom % 80) == 0;
      if ($urandom % 4 == 0) begin
        case ($urandom % 4)
          0: in0 = 8'($urandom);
          1: in1 = 8'($urandom);
          2: in2 = 8'($urandom);
          default: in3 = 8'($urandom);
        endcase
      end
      tick();
      n_cmp++;
      if (an !== e_an || sseg !== e_sseg || frame_start !== e_fs) begin
        n_bad++;
        $display("FAIL random i=%0d: got %b/%h/%b want %b/%h/%b", i, an, sseg, frame_start, e_an, e_sseg, e_fs);
      end
    end
    reset = 0; enable = 1;
  endtask

  initial begin
    #1;
    test_reset();
    test_frames();
    test_capture_atomic();
    test_enable_freeze();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
